// File: rtl/eco32f_pkg.sv
// Shared constants for the eco32f divider slice: FSM state codes and iteration count.
package eco32f_pkg;

  localparam int DIV_ITER = 32;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_FIX  = 2'd2;
  localparam state_t S_DONE = 2'd3;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/eco32f_div_core.sv
// Datapath of the shared restoring divider: operand magnitudes, subtract-shift step and sign fix.
module eco32f_div_core
  import eco32f_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic        step_i,
  input  logic        fix_i,
  input  logic        zero_res_i,
  input  logic        signed_i,
  input  logic        op_rem_i,
  input  logic [31:0] x_i,
  input  logic [31:0] y_i,
  output logic [31:0] result_o
);

  logic [31:0] n_q, n_d, r_q, r_d, d_q, d_d, res_q, res_d;
  logic        neg_q, neg_d, rem_q, rem_d;
  logic [32:0] diff;
  logic [31:0] mag;

  // n shifts quotient bits in from the right while the dividend drains out of its top bit.
  always_comb begin
    n_d   = n_q;
    r_d   = r_q;
    d_d   = d_q;
    neg_d = neg_q;
    rem_d = rem_q;
    res_d = res_q;
    diff  = {1'b0, r_q[30:0], n_q[31]} - {1'b0, d_q};
    mag   = rem_q ? r_q : n_q;
    if (load_i) begin
      n_d   = (signed_i && x_i[31]) ? neg32(x_i) : x_i;
      d_d   = (signed_i && y_i[31]) ? neg32(y_i) : y_i;
      neg_d = signed_i & (op_rem_i ? x_i[31] : (x_i[31] ^ y_i[31]));
      rem_d = op_rem_i;
      r_d   = '0;
    end else if (step_i) begin
      if (!diff[32]) begin
        r_d = diff[31:0];
        n_d = {n_q[30:0], 1'b1};
      end else begin
        r_d = {r_q[30:0], n_q[31]};
        n_d = {n_q[30:0], 1'b0};
      end
    end
    if (fix_i) begin
      res_d = zero_res_i ? '0 : (neg_q ? neg32(mag) : mag);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      n_q   <= '0;
      r_q   <= '0;
      d_q   <= '0;
      neg_q <= 1'b0;
      rem_q <= 1'b0;
      res_q <= '0;
    end else begin
      n_q   <= n_d;
      r_q   <= r_d;
      d_q   <= d_d;
      neg_q <= neg_d;
      rem_q <= rem_d;
      res_q <= res_d;
    end
  end

  assign result_o = res_q;

endmodule

// File: rtl/eco32f_div_arb.sv
// Round-robin arbiter and sequencer sharing one serial divider between the pipeline (port 0) and a secondary master (port 1).
// Build option ECO32F_DIV_ZERO_TRAP_EN: a zero divisor skips the iterations and reports div_by_zero with a zero result.
module eco32f_div_arb
  import eco32f_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic        op_rem0_i,
  input  logic        op_rem1_i,
  input  logic        signed0_i,
  input  logic        signed1_i,
  input  logic [31:0] x0_i,
  input  logic [31:0] y0_i,
  input  logic [31:0] x1_i,
  input  logic [31:0] y1_i,
  input  logic        flush0_i,
  output logic        gnt0_o,
  output logic        gnt1_o,
  output logic        done0_o,
  output logic        done1_o,
  output logic [31:0] result_o,
  output logic        div_by_zero_o,
  output logic        busy_o
);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        own_q, own_d, last_q, last_d;
  logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic        done0_q, done0_d, done1_q, done1_d;
  logic        req0Eff, win1, flushHit, loadEn, stepEn, fixEn, zeroRes;
  logic [31:0] xSel, ySel;
  logic        signedSel, opRemSel;

`ifdef ECO32F_DIV_ZERO_TRAP_EN
  logic dz_q, dz_d, dzOut_q;
  assign zeroRes       = dz_q;
  assign div_by_zero_o = dzOut_q;
`else
  assign zeroRes       = 1'b0;
  assign div_by_zero_o = 1'b0;
`endif

  // last_q == 0 means port 0 was granted last, so a tie goes to port 1.
  assign req0Eff   = req0_i & ~flush0_i;
  assign win1      = req1_i & (~req0Eff | ~last_q);
  assign xSel      = win1 ? x1_i : x0_i;
  assign ySel      = win1 ? y1_i : y0_i;
  assign signedSel = win1 ? signed1_i : signed0_i;
  assign opRemSel  = win1 ? op_rem1_i : op_rem0_i;
  assign flushHit  = flush0_i & gnt0_q & (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    own_d   = own_q;
    last_d  = last_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    loadEn  = 1'b0;
    stepEn  = 1'b0;
    fixEn   = 1'b0;
`ifdef ECO32F_DIV_ZERO_TRAP_EN
    dz_d    = dz_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req0Eff || req1_i) begin
          loadEn  = 1'b1;
          own_d   = win1;
          gnt0_d  = ~win1;
          gnt1_d  = win1;
          cnt_d   = 6'(DIV_ITER);
          state_d = S_RUN;
`ifdef ECO32F_DIV_ZERO_TRAP_EN
          dz_d = (ySel == '0);
          if (ySel == '0) state_d = S_FIX;
`endif
        end
      end
      S_RUN: begin
        stepEn = 1'b1;
        cnt_d  = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = S_FIX;
      end
      S_FIX: begin
        fixEn   = 1'b1;
        done0_d = ~own_q;
        done1_d = own_q;
        state_d = S_DONE;
      end
      default: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        last_d  = own_q;
        state_d = S_IDLE;
      end
    endcase
    // A pipeline flush abandons port 0's operation without a done pulse.
    if (flushHit) begin
      state_d = S_IDLE;
      gnt0_d  = 1'b0;
      last_d  = 1'b0;
      stepEn  = 1'b0;
      fixEn   = 1'b0;
      done0_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      own_q   <= 1'b0;
      last_q  <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      own_q   <= own_d;
      last_q  <= last_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

`ifdef ECO32F_DIV_ZERO_TRAP_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      dz_q    <= 1'b0;
      dzOut_q <= 1'b0;
    end else begin
      dz_q <= dz_d;
      if (fixEn) dzOut_q <= dz_q;
    end
  end
`endif

  eco32f_div_core u_core (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (loadEn),
    .step_i     (stepEn),
    .fix_i      (fixEn),
    .zero_res_i (zeroRes),
    .signed_i   (signedSel),
    .op_rem_i   (opRemSel),
    .x_i        (xSel),
    .y_i        (ySel),
    .result_o   (result_o)
  );

  assign gnt0_o  = gnt0_q;
  assign gnt1_o  = gnt1_q;
  assign done0_o = done0_q;
  assign done1_o = done1_q;
  assign busy_o  = (state_q != S_IDLE);

endmodule
